// File: rtl/dds_sine_core_if.sv
// Tuning-word handshake and signed sample stream of the DDS sine core.
// The core attaches through the slave modport; its feeder/consumer uses master.
interface dds_sine_core_if #(
  parameter int ACC_W = 32,
  parameter int OUT_W = 16
) ();
  logic [ACC_W-1:0]        ftw_data;
  logic                    ftw_valid;
  logic                    ftw_ready;
  logic signed [OUT_W-1:0] sample;
  logic                    sample_valid;

  modport master (
    output ftw_data,
    output ftw_valid,
    input  ftw_ready,
    input  sample,
    input  sample_valid
  );

  modport slave (
    input  ftw_data,
    input  ftw_valid,
    output ftw_ready,
    output sample,
    output sample_valid
  );
endinterface

// File: rtl/dds_sine_core.sv
// DDS sine generator: phase accumulator plus quarter-wave table, started only
// after the synchronised PLL lock has been stable for HOLDOFF cycles.
module dds_sine_core #(
  parameter int ACC_W   = 32,
  parameter int Q_W     = 8,
  parameter int OUT_W   = 16,
  parameter int HOLDOFF = 1024
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           pll_locked,
  input  logic           enable,
  output logic           running,
  dds_sine_core_if.slave bus
);

  localparam int  LUT_N = 1 << Q_W;
  localparam int  PK    = (1 << (OUT_W - 1)) - 1;
  localparam int  CNT_W = $clog2(HOLDOFF);
  localparam real PI    = 3.14159265358979323846;

  typedef enum logic [1:0] {
    ST_WAIT_LOCK,
    ST_HOLDOFF,
    ST_RUN
  } state_t;

  state_t             state;
  logic [CNT_W-1:0]   hold_cnt;
  logic               lk_meta;
  logic               lk_s;
  logic               lock_lost;
  logic               advance;

  logic [ACC_W-1:0]   acc;
  logic [ACC_W-1:0]   ftw_q;
  logic [Q_W+1:0]     phase;
  logic [Q_W-1:0]     idx;

  logic               v1, v2;
  logic               neg1, neg2;
  logic               peak1, peak2;
  logic [Q_W-1:0]     addr1;
  logic [OUT_W-1:0]   lut2;
  logic [OUT_W-1:0]   mag;

  // First quadrant of the sine, rounded to nearest, built at elaboration.
  logic [OUT_W-1:0]   lut_rom [LUT_N];

  for (genvar k = 0; k < LUT_N; k++) begin : g_lut
    localparam real ANG = 2.0 * PI * real'(k) / real'(4 * LUT_N);
    localparam int  VAL = $rtoi(real'(PK) * $sin(ANG) + 0.5);
    assign lut_rom[k] = OUT_W'(VAL);
  end

  assign lock_lost = (state != ST_WAIT_LOCK) && !lk_s;
  assign advance   = (state == ST_RUN) && enable;
  assign phase     = acc[ACC_W-1 -: Q_W+2];
  assign idx       = phase[Q_W-1:0];
  assign mag       = peak2 ? OUT_W'(PK) : lut2;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lk_meta <= 1'b0;
      lk_s    <= 1'b0;
    end else begin
      lk_meta <= pll_locked;
      lk_s    <= lk_meta;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= ST_WAIT_LOCK;
      hold_cnt <= '0;
      running  <= 1'b0;
    end else begin
      case (state)
        ST_WAIT_LOCK: begin
          hold_cnt <= '0;
          running  <= 1'b0;
          if (lk_s) state <= ST_HOLDOFF;
        end
        ST_HOLDOFF: begin
          if (!lk_s) begin
            state    <= ST_WAIT_LOCK;
            hold_cnt <= '0;
          end else if (hold_cnt == CNT_W'(HOLDOFF - 1)) begin
            state   <= ST_RUN;
            running <= 1'b1;
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        ST_RUN: begin
          if (!lk_s) begin
            state   <= ST_WAIT_LOCK;
            running <= 1'b0;
          end
        end
        default: begin
          state   <= ST_WAIT_LOCK;
          running <= 1'b0;
        end
      endcase
    end
  end

  // A word accepted this edge is only seen by the accumulator from the next edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bus.ftw_ready <= 1'b0;
      ftw_q         <= '0;
      acc           <= '0;
    end else begin
      bus.ftw_ready <= !(bus.ftw_valid && bus.ftw_ready);
      if (bus.ftw_valid && bus.ftw_ready) ftw_q <= bus.ftw_data;
      if (lock_lost)    acc <= '0;
      else if (advance) acc <= acc + ftw_q;
    end
  end

  // Odd quadrants mirror the table; idx=0 there falls off the table and is the peak.
  always_ff @(posedge clk) begin
    if (!rst_n || lock_lost) begin
      v1               <= 1'b0;
      v2               <= 1'b0;
      neg1             <= 1'b0;
      neg2             <= 1'b0;
      peak1            <= 1'b0;
      peak2            <= 1'b0;
      addr1            <= '0;
      lut2             <= '0;
      bus.sample       <= '0;
      bus.sample_valid <= 1'b0;
    end else begin
      v1               <= advance;
      neg1             <= phase[Q_W+1];
      peak1            <= phase[Q_W] && (idx == '0);
      addr1            <= phase[Q_W] ? (Q_W'(0) - idx) : idx;

      v2               <= v1;
      neg2             <= neg1;
      peak2            <= peak1;
      lut2             <= lut_rom[addr1];

      bus.sample_valid <= v2;
      if (!v2)       bus.sample <= '0;
      else if (neg2) bus.sample <= OUT_W'(0) - mag;
      else           bus.sample <= mag;
    end
  end

endmodule

// File: tb/tb_dds_sine_core.sv
// Bench for dds_sine_core: directed lock, handshake and tone steps plus random traffic,
// all compared against a model built from lock streaks, phase arithmetic and the sine table.
module tb_dds_sine_core;

  localparam int  ACC_W   = 32;
  localparam int  Q_W     = 8;
  localparam int  OUT_W   = 16;
  localparam int  HOLDOFF = 16;
  localparam int  PK      = 32767;
  localparam real PI      = 3.14159265358979323846;

  logic clk = 1'b0;
  logic rst_n;
  logic pll_locked;
  logic enable;
  logic running;

  dds_sine_core_if #(.ACC_W(ACC_W), .OUT_W(OUT_W)) bus ();

  dds_sine_core #(
    .ACC_W  (ACC_W),
    .Q_W    (Q_W),
    .OUT_W  (OUT_W),
    .HOLDOFF(HOLDOFF)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .pll_locked(pll_locked),
    .enable    (enable),
    .running   (running),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int tb_lut [256];
  int tone_exp [4] = '{0, 32767, 0, -32767};

  // Model: running means lock has been seen high for HOLDOFF+1 samples, two flops late.
  logic               m_run   = 1'b0;
  logic               m_ready = 1'b0;
  logic               s1      = 1'b0;
  logic               s2      = 1'b0;
  int                 streak  = 0;
  logic [31:0]        m_acc   = '0;
  logic [31:0]        m_ftw   = '0;
  logic               pv [3];
  logic signed [15:0] ps [3];
  logic               exp_valid  = 1'b0;
  logic signed [15:0] exp_sample = '0;

  function automatic logic signed [15:0] ref_sine(input logic [31:0] a);
    int p, idx, mag;
    p   = int'(a[31:22]);
    idx = p % 256;
    case (p / 256)
      0, 2:    mag = tb_lut[idx];
      default: mag = (idx == 0) ? PK : tb_lut[256 - idx];
    endcase
    if (p >= 512) mag = -mag;
    return 16'(mag);
  endfunction

  task automatic modelEdge();
    logic new_run;
    if (!rst_n) begin
      m_run = 1'b0; m_ready = 1'b0; s1 = 1'b0; s2 = 1'b0; streak = 0;
      m_acc = '0; m_ftw = '0;
      for (int i = 0; i < 3; i++) begin pv[i] = 1'b0; ps[i] = '0; end
      exp_valid = 1'b0; exp_sample = '0;
      return;
    end
    streak  = s2 ? streak + 1 : 0;
    new_run = (streak >= HOLDOFF + 1);
    s2 = s1;
    s1 = pll_locked;
    pv[2] = pv[1]; ps[2] = ps[1];
    pv[1] = pv[0]; ps[1] = ps[0];
    pv[0] = m_run && enable;
    ps[0] = ref_sine(m_acc);
    if (m_run && !new_run)
      for (int i = 0; i < 3; i++) pv[i] = 1'b0;
    exp_valid  = pv[2];
    exp_sample = pv[2] ? ps[2] : 16'sd0;
    if (!new_run)              m_acc = '0;
    else if (m_run && enable)  m_acc = m_acc + m_ftw;
    if (bus.ftw_valid && m_ready) begin
      m_ftw   = bus.ftw_data;
      m_ready = 1'b0;
    end else begin
      m_ready = 1'b1;
    end
    m_run = new_run;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h (cycle %0d)", tag, observed, expected, cyc);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic lk, input logic en,
                               input logic fv, input logic [31:0] fd);
    rst_n         = r;
    pll_locked    = lk;
    enable        = en;
    bus.ftw_valid = fv;
    bus.ftw_data  = fd;
    @(posedge clk);
    modelEdge();
    cyc++;
    #1;
    checkOutput("running",      32'(running),          32'(m_run));
    checkOutput("ftw_ready",    32'(bus.ftw_ready),    32'(m_ready));
    checkOutput("sample_valid", 32'(bus.sample_valid), 32'(exp_valid));
    checkOutput("sample",       32'(bus.sample),       32'(exp_sample));
    checkOutput("acc",          dut.acc,               m_acc);
  endtask

  task automatic waitRunning(output int edge_no);
    edge_no = -1;
    for (int i = 0; i < 40 && edge_no < 0; i++) begin
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, '0);
      if (running === 1'b1) edge_no = cyc;
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int t, f, run_edge, first_valid, fall_edge, n_pos, n_neg, n_zero, n_seen;
    logic [31:0] prev_acc;
    logic [31:0] step_exp [4];
    logic        ready_exp [4];
    logic        lk;
    int tone_q [$];

    for (int k = 0; k < 256; k++)
      tb_lut[k] = $rtoi($floor(real'(PK) * $sin(2.0 * PI * real'(k) / 1024.0) + 0.5));

    rst_n = 1'b0; pll_locked = 1'b0; enable = 1'b0;
    bus.ftw_valid = 1'b0; bus.ftw_data = '0;

    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, '0);
    checkOutput("rst_ready",   32'(bus.ftw_ready),    32'd0);
    checkOutput("rst_valid",   32'(bus.sample_valid), 32'd0);
    checkOutput("rst_running", 32'(running),          32'd0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, '0);
    checkOutput("ready_after_rst", 32'(bus.ftw_ready), 32'd1);

    // Quarter-step tone, lock rising at edge 10
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 32'h4000_0000);
    while (cyc < 9) applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, '0);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, '0);
    t = cyc;
    waitRunning(run_edge);
    checkOutput("lock_to_run", 32'(run_edge - t), 32'(HOLDOFF + 2));
    first_valid = -1;
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, '0);
      if (bus.sample_valid === 1'b1) begin
        if (first_valid < 0) first_valid = cyc;
        tone_q.push_back(int'(bus.sample));
      end
    end
    checkOutput("first_valid_latency", 32'(first_valid - run_edge), 32'd3);
    checkOutput("tone_count", 32'(tone_q.size() >= 8), 32'd1);
    for (int i = 0; i < 8 && i < tone_q.size(); i++)
      checkOutput("tone", 32'(tone_q[i]), 32'(tone_exp[i % 4]));

    // Handshake: A, A, B, B with the step following each acceptance by one edge
    step_exp  = '{32'h4000_0000, 32'h0040_0000, 32'h0040_0000, 32'h0080_0000};
    ready_exp = '{1'b0, 1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 4; i++) begin
      prev_acc = dut.acc;
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, (i < 2) ? 32'h0040_0000 : 32'h0080_0000);
      checkOutput("hs_step",  dut.acc - prev_acc, step_exp[i]);
      checkOutput("hs_ready", 32'(bus.ftw_ready), 32'(ready_exp[i]));
    end

    // One table step per sample over a full turn
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 32'h0040_0000);
    n_pos = 0; n_neg = 0; n_zero = 0; n_seen = 0;
    for (int i = 0; i < 1030; i++) begin
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, '0);
      if (i >= 4 && i < 4 + 1024 && bus.sample_valid === 1'b1) begin
        n_seen++;
        if (bus.sample == 16'sd32767)  n_pos++;
        if (bus.sample == -16'sd32767) n_neg++;
        if (bus.sample == 16'sd0)      n_zero++;
      end
    end
    checkOutput("sweep_count", 32'(n_seen), 32'd1024);
    checkOutput("sweep_pos_peak", 32'(n_pos), 32'd1);
    checkOutput("sweep_neg_peak", 32'(n_neg), 32'd1);
    checkOutput("sweep_zero", 32'(n_zero), 32'd2);

    for (int i = 0; i < 300; i++)
      applyStimulus(1'b1, 1'b1, $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0, $urandom);
    for (int i = 0; i < 10; i++) applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, '0);
    for (int i = 0; i < 20; i++) applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, '0);

    // Lock loss in RUN, then relock with the retained word
    fall_edge = -1;
    f = 0;
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, '0);
      if (i == 0) f = cyc;
      if (running === 1'b0 && fall_edge < 0) fall_edge = cyc;
    end
    checkOutput("loss_to_stop", 32'(fall_edge - f), 32'd2);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, '0);
    t = cyc;
    waitRunning(run_edge);
    checkOutput("relock_to_run", 32'(run_edge - t), 32'(HOLDOFF + 2));
    for (int i = 0; i < 12; i++) applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, '0);

    // Glitch during HOLDOFF restarts the count; then a decrementing accumulator
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFFF);
    for (int i = 0; i < 2; i++) applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, '0);
    for (int i = 0; i < 6; i++) applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, '0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, '0);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, '0);
    t = cyc;
    waitRunning(run_edge);
    checkOutput("glitch_to_run", 32'(run_edge - t), 32'(HOLDOFF + 2));
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, '0);
    checkOutput("wrap_acc", dut.acc, 32'hFFFF_FFFF);
    for (int i = 0; i < 30; i++) applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, '0);

    // Reset mid-stream
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, '0);
    checkOutput("midrst_running", 32'(running), 32'd0);
    checkOutput("midrst_valid", 32'(bus.sample_valid), 32'd0);
    checkOutput("midrst_sample", 32'(bus.sample), 32'd0);
    checkOutput("midrst_ready", 32'(bus.ftw_ready), 32'd0);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, '0);
    checkOutput("midrst_ready_back", 32'(bus.ftw_ready), 32'd1);

    // Random lock drops, enables and tuning words
    lk = 1'b1;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 59) == 0) lk = !lk;
      applyStimulus(1'b1, lk, $urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0, $urandom);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dds_sine_core.md
# dds_sine_core

Direct digital synthesis core for the sine generator. Runs in the PLL output clock domain (125 MHz) and consumes the PLL `locked` flag. After lock has been stable for a hold-off period, it produces one signed sine sample per clock from a phase accumulator and a quarter-wave lookup table. It feeds the downstream DAC/audio output path.

## Interface
- `ACC_W`, 32: phase accumulator width.
- `Q_W`, 8: quarter-wave table address width; the table has 2^Q_W entries.
- `OUT_W`, 16: signed sample width.
- `HOLDOFF`, 1024: cycles synchronised lock must stay high before running; minimum 2.
- `clk` in 1: PLL output clock.
- `rst_n` in 1: reset, synchronous, active-low.
- `pll_locked` in 1: PLL lock flag, asynchronous to `clk`.
- `ftw_data` in ACC_W: frequency tuning word.
- `ftw_valid` in 1: `ftw_data` is valid.
- `ftw_ready` out 1: core can accept a tuning word.
- `enable` in 1: advance the accumulator and emit samples while running.
- `sample` out OUT_W: signed two's-complement sine sample.
- `sample_valid` out 1: `sample` is valid this cycle.
- `running` out 1: state is RUN.

## Operation
- **Lock synchroniser:** `pll_locked` passes through 2 flops to give `lk_s`.
- **FSM states:** WAIT_LOCK, HOLDOFF, RUN.
  - WAIT_LOCK → HOLDOFF when `lk_s`=1. The hold-off counter is cleared in WAIT_LOCK.
  - HOLDOFF counts 0..HOLDOFF-1, then moves to RUN.
  - From HOLDOFF or RUN, `lk_s`=0 returns to WAIT_LOCK. On that transition the accumulator is cleared and the pipeline valids are flushed. The tuning word is retained.
- **Tuning word handshake:**
  - A transfer occurs when `ftw_valid` && `ftw_ready`. `ftw_ready` is accepted in any FSM state.
  - The accepted word is registered. It is used by the first accumulator update one cycle after acceptance.
  - `ftw_ready` deasserts for exactly the cycle after an accepted transfer, then reasserts. Back-to-back transfers are therefore accepted every 2nd cycle.
- **Accumulator:**
  - In RUN with `enable`=1: acc <= acc + ftw, modulo 2^ACC_W, wrapping silently.
  - Otherwise acc holds its value. The exception is leaving RUN or HOLDOFF for WAIT_LOCK, which clears it.
- **Phase decode:** p = acc[ACC_W-1 -: Q_W+2]; quadrant q = p[Q_W+1:Q_W]; idx = p[Q_W-1:0].
- **Table:** lut[k] = round((2^(OUT_W-1)-1)·sin(2π·k/2^(Q_W+2))) for k = 0..2^Q_W-1.
- **Sample mapping,** with PK = 2^(OUT_W-1)-1:
  - q0: lut[idx].
  - q1: PK if idx=0, else lut[2^Q_W-idx].
  - q2: -lut[idx].
  - q3: -PK if idx=0, else -lut[2^Q_W-idx].
  - The negation cannot overflow because |value| ≤ PK.
- **Pipeline:**
  - S1 registers q and the table address.
  - S2 registers the table read.
  - S3 registers the sign/peak result into `sample`.
- **Valid tracking:** `sample_valid` is a 3-deep delay of (state=RUN && `enable`), flushed on lock loss. `sample` = 0 whenever `sample_valid` = 0.

## Timing
- **Reset values:** `ftw_ready`=0, `sample`=0, `sample_valid`=0, `running`=0, acc=0, ftw register=0, state=WAIT_LOCK.
- **After reset:** `ftw_ready`=1 from the first cycle after `rst_n` is sampled high.
- **Lock-to-run latency:**
  - `pll_locked` sampled high at edge t gives `lk_s`=1 after edge t+1.
  - `running` rises HOLDOFF+2 cycles after t.
- **Sample latency:** the accumulator value registered at edge n appears on `sample` after edge n+3, with `sample_valid`=1.
- **Lock loss:** `running` falls 2 cycles after `pll_locked` falls. `sample_valid` and `sample` are 0 from that same cycle.
- **Lock glitch during HOLDOFF:** a lock glitch of 3 or more cycles during HOLDOFF restarts the count from 0.
- **Simultaneous handshake and update:** a tuning word accepted in the same cycle as an accumulator update does not affect that update.
- **`enable` falling in RUN:** the last 3 in-flight samples drain, then `sample_valid`=0.
- **`rst_n` low mid-operation:** all state returns to its reset values on the next edge.

## Test plan
- **Lock-to-run timing.** HOLDOFF=16, `pll_locked` rises at cycle 10 → `running`=1 at cycle 28; `sample_valid` first high 3 cycles later, with `sample`=0 (acc starts at 0).
- **Quarter-step tones.**
  - ftw=0x4000_0000 with `enable`=1 → `sample` sequence 0, 32767, 0, -32767, repeating.
  - ftw=0x0040_0000 → p increments by 1 per sample; output matches the lut mapping over 1024 samples, including the q1/q3 idx=0 peaks.
- **Handshake.** `ftw_valid` held high for 4 cycles with words A, A, B, B → A accepted, `ftw_ready` low, B accepted, `ftw_ready` low. The accumulator step changes to A, then to B, each one cycle after its acceptance.
- **Lock loss in RUN.** Drop `pll_locked` for 5 cycles → `running`, `sample_valid`, `sample` all 0 two cycles later; acc cleared. Relock → HOLDOFF restarts and samples restart from phase 0 with the retained ftw.
- **Enable and wrap.**
  - `enable` low for 10 cycles → acc frozen; samples resume from the same phase.
  - ftw=0xFFFF_FFFF → acc decrements by 1 modulo 2^32 with no glitch at the wrap.
- **Reset mid-stream.** `rst_n` low for 1 cycle while running → all outputs 0 next cycle; `ftw_ready`=1 the cycle after `rst_n` is sampled high.
